// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD/LCM coprocessor using Dijkstra subtraction with u/v accumulators for LCM.
// Latency k+2 cycles from Start (k subtraction steps); zero operands bypass to DONE in 1 cycle.
module gcd_lcm_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             LcmSel,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   x_q, y_q, result_q;
  logic [2*WIDTH-1:0] u_q, v_q;
  logic               sel_q, busy_q, done_q;

  logic [2*WIDTH:0]   uv_sum;
  logic [WIDTH-1:0]   lcm_d, bypass_d;

  // Extra bit keeps the carry so the halving is exact before truncation.
  assign uv_sum   = {1'b0, u_q} + {1'b0, v_q};
  assign lcm_d    = WIDTH'(uv_sum >> 1);
  assign bypass_d = LcmSel ? '0 : (SrcA | SrcB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      sel_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (SrcA == '0 || SrcB == '0) begin
              result_q <= bypass_d;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              x_q     <= SrcA;
              y_q     <= SrcB;
              u_q     <= {{WIDTH{1'b0}}, SrcB};
              v_q     <= {{WIDTH{1'b0}}, SrcA};
              sel_q   <= LcmSel;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (x_q > y_q) begin
            x_q <= x_q - y_q;
            v_q <= v_q + u_q;
          end else if (x_q < y_q) begin
            y_q <= y_q - x_q;
            u_q <= u_q + v_q;
          end else begin
            result_q <= sel_q ? lcm_d : x_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Result = result_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Bench for gcd_lcm_unit: directed vector table, reset-abort and 8-bit truncation sequences, random ops vs model.
module tb_gcd_lcm_unit;

  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        st32, sel32, busy32, done32;
  logic [31:0] a32, b32, res32;
  logic        st8, sel8, busy8, done8;
  logic [7:0]  a8, b8, res8;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev32 = 0;
  logic [31:0] prev8  = 0;

  always #5 clk = ~clk;

  gcd_lcm_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .Start(st32), .SrcA(a32), .SrcB(b32),
    .LcmSel(sel32), .Result(res32), .Busy(busy32), .Done(done32)
  );

  gcd_lcm_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Start(st8), .SrcA(a8), .SrcB(b8),
    .LcmSel(sel8), .Result(res8), .Busy(busy8), .Done(done8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sel;
    logic [31:0] res;
    int          cyc;
    bit          inj;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Reference: gcd by Euclid's remainder, lcm = a/g*b, step count from the subtraction rule.
  function automatic void model(input longint unsigned a, input longint unsigned b, input bit sel,
                                input int w, output logic [31:0] res, output int cyc);
    longint unsigned g, r, p, q, full;
    int k;
    if (a == 0 || b == 0) begin
      full = sel ? 64'd0 : (a | b);
      cyc  = 1;
    end else begin
      p = a; q = b;
      while (q != 0) begin r = p % q; p = q; q = r; end
      g = p;
      p = a; q = b; k = 0;
      while (p != q) begin
        if (p > q) p = p - q; else q = q - p;
        k++;
      end
      full = sel ? (a / g) * b : g;
      cyc  = k + 2;
    end
    full = full & ((64'd1 << w) - 1);
    res  = full[31:0];
  endfunction

  task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit sel,
                        input logic [31:0] exp_res, input int exp_cyc, input bit inject, input string nm);
    int dcyc, busy_cnt;
    logic [31:0] r;
    @(posedge clk); #1;
    check({nm, " idle done"}, w8 ? 32'(done8) : 32'(done32), 0);
    check({nm, " idle busy"}, w8 ? 32'(busy8) : 32'(busy32), 0);
    check({nm, " held result"}, w8 ? {24'd0, res8} : res32, w8 ? prev8 : prev32);
    if (w8) begin st8 = 1; a8 = a[7:0]; b8 = b[7:0]; sel8 = sel; end
    else begin st32 = 1; a32 = a; b32 = b; sel32 = sel; end
    dcyc = -1;
    busy_cnt = 0;
    for (int n = 1; n <= LIMIT && dcyc < 0; n++) begin
      @(posedge clk); #1;
      if (w8) begin
        st8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 1'($urandom);
        if (busy8) busy_cnt++;
        if (done8) dcyc = n;
      end else begin
        if (inject && n >= 10 && n <= 12) begin
          st32 = 1; a32 = 5; b32 = 5; sel32 = 1;
        end else begin
          st32 = 0; a32 = $urandom; b32 = $urandom; sel32 = 1'($urandom);
        end
        if (busy32) busy_cnt++;
        if (done32) dcyc = n;
      end
    end
    st8 = 0; st32 = 0;
    if (dcyc < 0) begin
      errors++;
      checks++;
      $display("FAIL %s done timeout: no Done within %0d cycles, expected cycle %0d", nm, LIMIT, exp_cyc);
    end else begin
      check({nm, " done cycle"}, dcyc, exp_cyc);
      r = w8 ? {24'd0, res8} : res32;
      check({nm, " result"}, r, exp_res);
      check({nm, " busy cycles"}, busy_cnt, (exp_cyc == 1) ? 0 : exp_cyc - 1);
    end
    if (w8) prev8 = exp_res; else prev32 = exp_res;
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    bit          rs;
    int          ec;

    vt[0] = '{a: 4,   b: 6, sel: 0, res: 2,  cyc: 4,   inj: 0};
    vt[1] = '{a: 4,   b: 6, sel: 1, res: 12, cyc: 4,   inj: 0};
    vt[2] = '{a: 21,  b: 6, sel: 1, res: 42, cyc: 6,   inj: 0};
    vt[3] = '{a: 0,   b: 9, sel: 0, res: 9,  cyc: 1,   inj: 0};
    vt[4] = '{a: 0,   b: 9, sel: 1, res: 0,  cyc: 1,   inj: 0};
    vt[5] = '{a: 0,   b: 0, sel: 0, res: 0,  cyc: 1,   inj: 0};
    vt[6] = '{a: 7,   b: 7, sel: 0, res: 7,  cyc: 2,   inj: 0};
    vt[7] = '{a: 100, b: 1, sel: 0, res: 1,  cyc: 101, inj: 1};

    reset = 1;
    st32 = 0; a32 = 0; b32 = 0; sel32 = 0;
    st8 = 0;  a8 = 0;  b8 = 0;  sel8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", res32, 0);
    check("reset busy", 32'(busy32), 0);
    check("reset done", 32'(done32), 0);
    check("reset result8", {24'd0, res8}, 0);
    reset = 0;

    for (int i = 0; i < 8; i++)
      run_op(0, vt[i].a, vt[i].b, vt[i].sel, vt[i].res, vt[i].cyc, vt[i].inj, $sformatf("vec%0d", i));

    // Reset during CALC aborts without a Done pulse.
    @(posedge clk); #1;
    st32 = 1; a32 = 48; b32 = 18; sel32 = 0;
    @(posedge clk); #1;
    st32 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-abort busy", 32'(busy32), 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("abort busy", 32'(busy32), 0);
    check("abort done", 32'(done32), 0);
    check("abort result", res32, 0);
    @(posedge clk); #1;
    check("abort no done", 32'(done32), 0);
    prev32 = 0;
    prev8  = 0;
    run_op(0, 48, 18, 0, 6, 6, 0, "post-abort");

    run_op(1, 255, 254, 1, 2, 256, 0, "w8 lcm trunc");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom_range(1, 60);
      rb = $urandom_range(1, 60);
      if ($urandom_range(0, 7) == 0) ra = 0;
      if ($urandom_range(0, 7) == 0) rb = 0;
      rs = 1'($urandom);
      model(ra, rb, rs, 32, er, ec);
      run_op(0, ra, rb, rs, er, ec, 0, $sformatf("rnd%0d a=%0d b=%0d l=%0d", i, ra, rb, rs));
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom_range(0, 40);
      rb = $urandom_range(1, 40);
      rs = 1'($urandom);
      model(ra, rb, rs, 8, er, ec);
      run_op(1, ra, rb, rs, er, ec, 0, $sformatf("rnd8_%0d a=%0d b=%0d l=%0d", i, ra, rb, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
